// File: rtl/input_controller.sv
// ---------------------------------------------------------------------------
// InputController: AXI-Stream slave on the receive side of the transceiver.
// Accepts one frame at a time and writes its beats into a SIZE-word buffer
// through a registered synchronous RAM write port. A finished frame is held,
// with tready_out low, until the downstream consumer pulses frame_ack.
// Beats past SIZE are accepted but discarded and flag the frame as truncated.
//
// Ports:
//   clk_in, rst_n_in        single rising-edge clock, async active-low reset
//   tdata_in/tvalid_in/
//   tlast_in/tready_out     stream slave (ready decoded from state only)
//   wr_data/wr_addr/wr_en   RAM write port, one cycle after the beat
//   frame_valid/frame_len/
//   frame_ovf               description of the held frame
//   frame_ack               consumer done, release the buffer (HOLD only)
//   frame_cnt               completed frames since reset, wraps 255->0
// ---------------------------------------------------------------------------
module input_controller #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 10
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [DATA_WIDTH-1:0]        tdata_in,
  input  logic                         tvalid_in,
  input  logic                         tlast_in,
  output logic                         tready_out,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic                         wr_en,
  output logic                         frame_valid,
  output logic [$clog2(SIZE+1)-1:0]    frame_len,
  output logic                         frame_ovf,
  input  logic                         frame_ack,
  output logic [7:0]                   frame_cnt
);

  localparam int LEN_W = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP,
    HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    beat;
  logic                    store;
  logic                    enterHold;

  logic                    wrEn_q;
  logic [ADDR_WIDTH-1:0]   wrAddr_q;
  logic [DATA_WIDTH-1:0]   wrData_q;
  logic                    frameValid_q;
  logic [LEN_W-1:0]        frameLen_q;
  logic                    frameOvf_q;
  logic [7:0]              frameCnt_q;

  // Ready depends only on the registered state, so there is no combinational
  // path from tvalid_in back to tready_out.
  assign tready_out = (state_q != HOLD);
  assign beat       = tvalid_in & tready_out;
  assign enterHold  = (state_d == HOLD) && (state_q != HOLD);

  // Next-state logic. cnt_q is both the word count and the write address of
  // the next stored beat; it is zero in IDLE, so the first beat lands at 0.
  // Once cnt_q reaches SIZE further beats only set the overflow flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    store   = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          store   = 1'b1;
          cnt_d   = LEN_W'(1);
          state_d = tlast_in ? HOLD : RECV;
        end
      end
      RECV: begin
        if (beat) begin
          if (cnt_q < LEN_W'(SIZE)) begin
            store   = 1'b1;
            cnt_d   = cnt_q + LEN_W'(1);
            state_d = tlast_in ? HOLD : RECV;
          end else begin
            ovf_d   = 1'b1;
            state_d = tlast_in ? HOLD : DROP;
          end
        end
      end
      DROP: begin
        if (beat && tlast_in) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // State, counter and overflow flag registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Registered write port: address and data hold their last values when no
  // beat is being stored, only the strobe drops.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
    end else begin
      wrEn_q <= store;
      if (store) begin
        wrAddr_q <= ADDR_WIDTH'(cnt_q);
        wrData_q <= tdata_in;
      end
    end
  end

  // Frame descriptor is registered from next-state values so it appears in
  // the same cycle as the final write strobe of the frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frameValid_q <= 1'b0;
      frameLen_q   <= '0;
      frameOvf_q   <= 1'b0;
      frameCnt_q   <= '0;
    end else begin
      frameValid_q <= (state_d == HOLD);
      frameLen_q   <= (state_d == HOLD) ? cnt_d : '0;
      frameOvf_q   <= (state_d == HOLD) && ovf_d;
      if (enterHold) begin
        frameCnt_q <= frameCnt_q + 8'd1;
      end
    end
  end

  assign wr_en       = wrEn_q;
  assign wr_addr     = wrAddr_q;
  assign wr_data     = wrData_q;
  assign frame_valid = frameValid_q;
  assign frame_len   = frameLen_q;
  assign frame_ovf   = frameOvf_q;
  assign frame_cnt   = frameCnt_q;

endmodule
